// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit with a fixed width+1 cycle latency.
// Define MULDIV_DIVIDE_EN to build the divider; without it funct3 4-7 return 0.
module mul_div_unit #(
  parameter int width   = 32,
  parameter int cnt_len = $clog2(width) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [width-1:0] rs1,
  input  logic [width-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state_q, state_d;
  logic [cnt_len-1:0]   cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [width-1:0]     opnd_q, opnd_d;
  logic [2*width-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [width-1:0]     result_q, result_d;

  logic                 s1, s2;
  logic [width-1:0]     mag1, mag2;
  logic [width:0]       mul_sum;
  logic [2*width-1:0]   prod_fix;

`ifdef MULDIV_DIVIDE_EN
  logic                 rem_neg_q, rem_neg_d;
  logic                 div_zero_q, div_zero_d;
  logic                 ovf_q, ovf_d;
  logic [width:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [width-1:0]     quo_fix, rem_fix;
`endif

  assign s1   = rs1[width-1];
  assign s2   = rs2[width-1];
  assign mag1 = s1 ? -rs1 : rs1;
  assign mag2 = s2 ? -rs2 : rs2;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*width-1:width]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(width+1){1'b0}});
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIVIDE_EN
  assign div_shift = {acc_q[2*width-1:width], acc_q[width-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // Divide-by-zero remainder needs no override: the magnitude path already yields rs1
  always_comb begin
    quo_fix = neg_q ? -acc_q[width-1:0] : acc_q[width-1:0];
    rem_fix = rem_neg_q ? -acc_q[2*width-1:width] : acc_q[2*width-1:width];
    if (div_zero_q) begin
      quo_fix = {width{1'b1}};
    end else if (ovf_q) begin
      quo_fix = {1'b1, {(width-1){1'b0}}};
      rem_fix = '0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef MULDIV_DIVIDE_EN
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = funct3;
          cnt_d   = '0;
          state_d = CALC;
          neg_d   = 1'b0;
          opnd_d  = rs1;
          acc_d   = {{width{1'b0}}, rs2};
          case (funct3)
            3'd1: begin
              opnd_d = mag1;
              acc_d  = {{width{1'b0}}, mag2};
              neg_d  = s1 ^ s2;
            end
            3'd2: begin
              opnd_d = mag1;
              neg_d  = s1;
            end
            default: ;
          endcase
`ifdef MULDIV_DIVIDE_EN
          if (funct3[2]) begin
            opnd_d     = funct3[0] ? rs2 : mag2;
            acc_d      = {{width{1'b0}}, (funct3[0] ? rs1 : mag1)};
            neg_d      = ~funct3[0] & (s1 ^ s2);
            rem_neg_d  = ~funct3[0] & s1;
            div_zero_d = ~|rs2;
            ovf_d      = ~funct3[0] & (rs1 == {1'b1, {(width-1){1'b0}}}) & (&rs2);
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + cnt_len'(1);
        acc_d = {mul_sum, acc_q[width-1:1]};
`ifdef MULDIV_DIVIDE_EN
        if (op_q[2]) begin
          acc_d = div_ge ? {div_diff[width-1:0], acc_q[width-2:0], 1'b1}
                         : {div_shift[width-1:0], acc_q[width-2:0], 1'b0};
        end
`endif
        if (cnt_q == cnt_len'(width - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == 3'd0) begin
          result_d = prod_fix[width-1:0];
        end else begin
          result_d = prod_fix[2*width-1:width];
        end
`ifdef MULDIV_DIVIDE_EN
        if (op_q[2]) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end
`else
        if (op_q[2]) begin
          result_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_DIVIDE_EN
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef MULDIV_DIVIDE_EN
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (width=32); expectations follow MULDIV_DIVIDE_EN.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MULDIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string        name;
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  mul_div_unit #(.width(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, wanted 0x%h", name, actual, expected);
    end
  endtask

  function automatic void addVec(input string n, input logic [2:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] e);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Division results collapse to zero when the divider is not built
  function automatic logic [W-1:0] divExp(input logic [W-1:0] e);
    return DIV_EN ? e : '0;
  endfunction

  // Launch one op, scramble the inputs after accept, count edges until done
  task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a,
                               input logic [W-1:0] b, output logic [W-1:0] res,
                               output int lat, output int busyCnt);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
    busyCnt = busy ? 1 : 0;
    lat = 0;
    res = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        res = result;
        break;
      end
      if (busy) busyCnt++;
    end
  endtask

  initial begin
    logic [W-1:0] res;
    int lat, bc, gap, doneSeen;

    reset = 1'b0; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;

    addVec("mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    addVec("mul_6_7",      3'd0, 32'd6,        32'd7,        32'd42);
    addVec("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    addVec("mulh_m3_7",    3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF);
    addVec("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    addVec("mulhu_small",  3'd3, 32'h12345678, 32'h00000010, 32'h00000001);
    addVec("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    addVec("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        divExp(32'hFFFFFFFD));
    addVec("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        divExp(32'hFFFFFFFF));
    addVec("divu_100_7",   3'd5, 32'd100,      32'd7,        divExp(32'd14));
    addVec("remu_100_7",   3'd7, 32'd100,      32'd7,        divExp(32'd2));
    addVec("div_5_0",      3'd4, 32'd5,        32'd0,        divExp(32'hFFFFFFFF));
    addVec("rem_5_0",      3'd6, 32'd5,        32'd0,        divExp(32'd5));
    addVec("divu_5_0",     3'd5, 32'd5,        32'd0,        divExp(32'hFFFFFFFF));
    addVec("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, divExp(32'h80000000));
    addVec("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, divExp(32'd0));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",   W'(busy), '0);
    checkOutput("reset_done",   W'(done), '0);
    checkOutput("reset_result", result,   '0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bc);
      checkOutput(vecs[i].name, res, vecs[i].exp);
      checkOutput({vecs[i].name, "_latency"}, W'(lat), 32'd33);
      checkOutput({vecs[i].name, "_busy_cycles"}, W'(bc), 32'd33);
      checkOutput({vecs[i].name, "_busy_at_done"}, W'(busy), '0);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_done_pulse"}, W'(done), '0);
    end

    // start held high with new operands while busy must not re-capture
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
    @(posedge clk); #1;
    funct3 = 3'd3; rs1 = 32'd100; rs2 = 32'd100;
    lat = 0; res = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 20) start = 1'b0;
      if (done) begin
        res = result;
        break;
      end
    end
    checkOutput("ignore_start_result",  res,     32'd42);
    checkOutput("ignore_start_latency", W'(lat), 32'd33);

    // start raised in the done cycle is accepted on the very next edge
    applyStimulus(3'd0, 32'd3, 32'd5, res, lat, bc);
    checkOutput("b2b_first_result", res, 32'd15);
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    gap = 1;
    checkOutput("b2b_accept_busy", W'(busy), 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      gap++;
      if (done) break;
    end
    checkOutput("b2b_second_result", result,  32'd81);
    checkOutput("b2b_done_gap",      W'(gap), 32'd34);

    // Async reset during CALC aborts the op and clears the outputs at once
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_busy",   W'(busy), '0);
    checkOutput("abort_done",   W'(done), '0);
    checkOutput("abort_result", result,   '0);
    @(negedge clk);
    reset = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", W'(doneSeen), '0);

    applyStimulus(3'd0, 32'd6, 32'd7, res, lat, bc);
    checkOutput("post_reset_mul",     res,     32'd42);
    checkOutput("post_reset_latency", W'(lat), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
